minefield_ctrl: RTL and testbench

MINEFIELD_CTRL -- requirements
Module: minefield_ctrl

---
 rtl/minefield_pkg.sv | 21 ++
 rtl/lfsr16.sv | 32 +++
 rtl/minefield_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_minefield_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minefield_pkg.sv
// Shared constants for the minefield controller: FSM state codes, LFSR shape,
// neighbour-count width and the cell-index width helper.
package minefield_pkg;

    localparam int unsigned ADJ_W     = 4;
    localparam int unsigned LFSR_W    = 16;
    // Fibonacci taps 16,14,13,11 expressed as a mask over q[15:0].
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] StIdle  = 3'd0;
    localparam logic [STATE_W-1:0] StPlace = 3'd1;
    localparam logic [STATE_W-1:0] StPlay  = 3'd2;
    localparam logic [STATE_W-1:0] StLost  = 3'd3;
    localparam logic [STATE_W-1:0] StWon   = 3'd4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a zero seed is replaced by 1 so the
// register can never lock up.
module lfsr16
    import minefield_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] seed_eff;
    logic [LFSR_W-1:0] q_d;
    logic [LFSR_W-1:0] q_q;

    assign seed_eff = (seed == '0) ? LFSR_W'(1) : seed;

    always_comb begin
        q_d = {q_q[LFSR_W-2:0], ^(q_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= seed_eff;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/minefield_ctrl.sv
// Minesweeper game controller: random bomb placement, reveal handshake, win/loss.
// Define MINEFIELD_ADJ_COUNT_EN to report the neighbouring bomb count on res_adj.
module minefield_ctrl
    import minefield_pkg::*;
#(
    parameter int unsigned   ROWS      = 4,
    parameter int unsigned   COLS      = 4,
    parameter int unsigned   NUM_BOMBS = 4,
    parameter logic [15:0]   SEED      = 16'hACE1,
    localparam int unsigned  N         = ROWS * COLS,
    localparam int unsigned  IDX_W     = idx_width(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rev_valid,
    output logic             rev_ready,
    input  logic [IDX_W-1:0] rev_idx,
    output logic             res_valid,
    output logic             res_bomb,
    output logic             res_dup,
    output logic [ADJ_W-1:0] res_adj,
    output logic [N-1:0]     revealed,
    output logic [IDX_W:0]   safe_cnt,
    output logic             busy,
    output logic             game_over,
    output logic             win
);

    localparam logic [IDX_W:0] NCells     = (IDX_W+1)'(N);
    localparam logic [IDX_W:0] BombTarget = (IDX_W+1)'(NUM_BOMBS);
    localparam logic [IDX_W:0] SafeTarget = (IDX_W+1)'(N - NUM_BOMBS);

    logic [STATE_W-1:0] state_d, state_q;
    logic [N-1:0]       bomb_d, bomb_q;
    logic [N-1:0]       revealed_d, revealed_q;
    logic [IDX_W:0]     safe_cnt_d, safe_cnt_q;
    logic [IDX_W:0]     placed_d, placed_q;
    logic               res_valid_d, res_valid_q;
    logic               res_bomb_d, res_bomb_q;
    logic               res_dup_d, res_dup_q;
    logic [ADJ_W-1:0]   res_adj_d, res_adj_q;

    logic [LFSR_W-1:0]  lfsr_q;
    logic [IDX_W-1:0]   cand;
    logic               accept;
    logic               idx_ok;
    logic [ADJ_W-1:0]   adj;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    assign cand   = lfsr_q[IDX_W-1:0];
    assign accept = rev_valid && rev_ready;
    assign idx_ok = ({1'b0, rev_idx} < NCells);

`ifdef MINEFIELD_ADJ_COUNT_EN
    localparam int RowsI = int'(ROWS);
    localparam int ColsI = int'(COLS);

    int               adj_row, adj_col, nr, nc;
    logic [IDX_W-1:0] nidx;

    // Neighbours outside the grid are skipped rather than wrapped.
    always_comb begin
        adj     = '0;
        adj_row = int'(rev_idx) / ColsI;
        adj_col = int'(rev_idx) % ColsI;
        nr      = 0;
        nc      = 0;
        nidx    = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr   = adj_row + dr;
                nc   = adj_col + dc;
                nidx = IDX_W'(nr * ColsI + nc);
                if (!(dr == 0 && dc == 0) && nr >= 0 && nr < RowsI &&
                    nc >= 0 && nc < ColsI && bomb_q[nidx]) begin
                    adj = adj + ADJ_W'(1);
                end
            end
        end
    end
`else
    assign adj = '0;
`endif

    always_comb begin
        state_d     = state_q;
        bomb_d      = bomb_q;
        revealed_d  = revealed_q;
        safe_cnt_d  = safe_cnt_q;
        placed_d    = placed_q;
        res_valid_d = 1'b0;
        res_bomb_d  = 1'b0;
        res_dup_d   = 1'b0;
        res_adj_d   = '0;

        // start overrides everything, including a reveal accepted this cycle.
        if (start) begin
            state_d    = StPlace;
            bomb_d     = '0;
            revealed_d = '0;
            safe_cnt_d = '0;
            placed_d   = '0;
        end else begin
            case (state_q)
                StPlace: begin
                    if ({1'b0, cand} < NCells && !bomb_q[cand]) begin
                        bomb_d[cand] = 1'b1;
                        placed_d     = placed_q + 1'b1;
                        if (placed_q + 1'b1 == BombTarget) begin
                            state_d = StPlay;
                        end
                    end
                end
                StPlay: begin
                    if (accept && idx_ok) begin
                        res_valid_d = 1'b1;
                        res_adj_d   = adj;
                        if (bomb_q[rev_idx]) begin
                            res_bomb_d          = 1'b1;
                            revealed_d[rev_idx] = 1'b1;
                            state_d             = StLost;
                        end else if (revealed_q[rev_idx]) begin
                            res_dup_d = 1'b1;
                        end else begin
                            revealed_d[rev_idx] = 1'b1;
                            safe_cnt_d          = safe_cnt_q + 1'b1;
                            if (safe_cnt_q + 1'b1 == SafeTarget) begin
                                state_d = StWon;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bomb_q      <= '0;
            revealed_q  <= '0;
            safe_cnt_q  <= '0;
            placed_q    <= '0;
            res_valid_q <= 1'b0;
            res_bomb_q  <= 1'b0;
            res_dup_q   <= 1'b0;
            res_adj_q   <= '0;
        end else begin
            state_q     <= state_d;
            bomb_q      <= bomb_d;
            revealed_q  <= revealed_d;
            safe_cnt_q  <= safe_cnt_d;
            placed_q    <= placed_d;
            res_valid_q <= res_valid_d;
            res_bomb_q  <= res_bomb_d;
            res_dup_q   <= res_dup_d;
            res_adj_q   <= res_adj_d;
        end
    end

    assign rev_ready = (state_q == StPlay);
    assign busy      = (state_q == StPlace);
    assign game_over = (state_q == StLost);
    assign win       = (state_q == StWon);
    assign res_valid = res_valid_q;
    assign res_bomb  = res_bomb_q;
    assign res_dup   = res_dup_q;
    assign res_adj   = res_adj_q;
    assign revealed  = revealed_q;
    assign safe_cnt  = safe_cnt_q;

endmodule

// File: tb/tb_minefield_ctrl.sv
// Self-checking bench for minefield_ctrl (4x4, 4 bombs) with a reference LFSR,
// placement model and result scoreboard.
module tb_minefield_ctrl;

    localparam int          CELLS = 16;
    localparam int          NB    = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    typedef struct packed {
        logic        bomb;
        logic        dup;
        logic [3:0]  adj;
        logic [4:0]  safe;
        logic        over;
        logic        win;
        logic [15:0] rev;
    } exp_t;

    typedef struct packed {
        logic [3:0] idx;
        exp_t       e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rev_valid;
    logic        rev_ready;
    logic [3:0]  rev_idx;
    logic        res_valid;
    logic        res_bomb;
    logic        res_dup;
    logic [3:0]  res_adj;
    logic [15:0] revealed;
    logic [4:0]  safe_cnt;
    logic        busy;
    logic        game_over;
    logic        win;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t sb_q[$];
    vec_t vecs[$];

    logic [15:0] m_lfsr;
    logic [15:0] m_bombs;
    logic [15:0] m_rev;
    int          m_safe;
    logic        m_over;
    logic        m_win;

    minefield_ctrl #(
        .ROWS      (4),
        .COLS      (4),
        .NUM_BOMBS (NB),
        .SEED      (SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rev_valid (rev_valid),
        .rev_ready (rev_ready),
        .rev_idx   (rev_idx),
        .res_valid (res_valid),
        .res_bomb  (res_bomb),
        .res_dup   (res_dup),
        .res_adj   (res_adj),
        .revealed  (revealed),
        .safe_cnt  (safe_cnt),
        .busy      (busy),
        .game_over (game_over),
        .win       (win)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_sb();
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("res_valid", {31'd0, res_valid}, 32'd1);
            chk("res_bomb", {31'd0, res_bomb}, {31'd0, e.bomb});
            chk("res_dup", {31'd0, res_dup}, {31'd0, e.dup});
            chk("res_adj", {28'd0, res_adj}, {28'd0, e.adj});
            chk("safe_cnt", {27'd0, safe_cnt}, {27'd0, e.safe});
            chk("game_over", {31'd0, game_over}, {31'd0, e.over});
            chk("win", {31'd0, win}, {31'd0, e.win});
            chk("revealed", {16'd0, revealed}, {16'd0, e.rev});
            chk("rev_ready_after", {31'd0, rev_ready}, {31'd0, !(e.over || e.win)});
        end else begin
            chk("res_valid_idle", {31'd0, res_valid}, 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_sb();
    endtask

    function automatic logic [3:0] adj_of(input logic [15:0] bm, input int idx);
        int r, c;
        logic [3:0] n;
        r = idx / 4;
        c = idx % 4;
        n = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 4 &&
                    c + dc >= 0 && c + dc < 4 && bm[(r + dr) * 4 + c + dc]) begin
                    n = n + 4'd1;
                end
            end
        end
        return n;
    endfunction

    function automatic exp_t model_reveal(input int idx);
        exp_t e;
        e = '0;
`ifdef MINEFIELD_ADJ_COUNT_EN
        e.adj = adj_of(m_bombs, idx);
`else
        e.adj = 4'd0;
`endif
        if (m_bombs[idx]) begin
            e.bomb      = 1'b1;
            m_rev[idx]  = 1'b1;
            m_over      = 1'b1;
        end else if (m_rev[idx]) begin
            e.dup = 1'b1;
        end else begin
            m_rev[idx] = 1'b1;
            m_safe++;
            if (m_safe == CELLS - NB) m_win = 1'b1;
        end
        e.safe = 5'(m_safe);
        e.over = m_over;
        e.win  = m_win;
        e.rev  = m_rev;
        return e;
    endfunction

    task automatic add_vec(input int idx);
        vec_t v;
        v.idx = 4'(idx);
        v.e   = model_reveal(idx);
        vecs.push_back(v);
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            chk("rev_ready_before", {31'd0, rev_ready}, 32'd1);
            rev_valid = 1'b1;
            rev_idx   = vecs[i].idx;
            sb_q.push_back(vecs[i].e);
            tick();
            rev_valid = 1'b0;
        end
        vecs.delete();
    endtask

    task automatic model_place(input logic [15:0] l0, output logic [15:0] bm, output int cyc);
        logic [15:0] v;
        int placed;
        v = l0;
        bm = '0;
        placed = 0;
        cyc = 0;
        while (placed < NB && cyc < 10000) begin
            if (!bm[v[3:0]]) begin
                bm[v[3:0]] = 1'b1;
                placed++;
            end
            v = lfsr_next(v);
            cyc++;
        end
    endtask

    task automatic do_start(output logic [15:0] bm);
        int cyc, cnt;
        start = 1'b1;
        tick();
        start     = 1'b0;
        rev_valid = 1'b0;
        model_place(m_lfsr, bm, cyc);
        m_bombs = bm;
        m_rev   = '0;
        m_safe  = 0;
        m_over  = 1'b0;
        m_win   = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("safe_cnt_cleared", {27'd0, safe_cnt}, 32'd0);
        chk("revealed_cleared", {16'd0, revealed}, 32'd0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 500) begin
            cnt++;
            tick();
        end
        chk("place_cycles", cnt, cyc);
        chk("rev_ready_play", {31'd0, rev_ready}, 32'd1);
        chk("game_over_play", {31'd0, game_over}, 32'd0);
        chk("win_play", {31'd0, win}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rev_ready"}, {31'd0, rev_ready}, 32'd0);
        chk({tag, "_game_over"}, {31'd0, game_over}, 32'd0);
        chk({tag, "_win"}, {31'd0, win}, 32'd0);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_res_bomb"}, {31'd0, res_bomb}, 32'd0);
        chk({tag, "_res_dup"}, {31'd0, res_dup}, 32'd0);
        chk({tag, "_res_adj"}, {28'd0, res_adj}, 32'd0);
        chk({tag, "_safe_cnt"}, {27'd0, safe_cnt}, 32'd0);
        chk({tag, "_revealed"}, {16'd0, revealed}, 32'd0);
    endtask

    task automatic reset_seq(input int k);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (k) tick();
    endtask

    function automatic int first_cell(input logic [15:0] bm, input logic want_bomb, input int skip);
        int seen;
        seen = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (bm[i] == want_bomb) begin
                if (seen == skip) return i;
                seen++;
            end
        end
        return 0;
    endfunction

    task automatic add_all_safe(input logic [15:0] bm, input logic with_dup);
        int n;
        int last;
        n = 0;
        last = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (!bm[i]) begin
                add_vec(i);
                n++;
                if (with_dup && n == 3) add_vec(i);
                last = i;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bm_first;
        logic [15:0] bm;
        int s0, s1, b0;

        reset     = 1'b1;
        start     = 1'b0;
        rev_valid = 1'b0;
        rev_idx   = '0;

        // Game 1: lose on a known bomb after a safe reveal and its duplicate.
        reset_seq(3);
        do_start(bm_first);
        s0 = first_cell(bm_first, 1'b0, 0);
        b0 = first_cell(bm_first, 1'b1, 0);
        add_vec(s0);
        add_vec(s0);
        add_vec(b0);
        run_table();
        rev_valid = 1'b1;
        rev_idx   = 4'(s0);
        repeat (3) tick();
        rev_valid = 1'b0;
        chk("lost_sticky", {31'd0, game_over}, 32'd1);
        chk("lost_rev_ready", {31'd0, rev_ready}, 32'd0);
        chk("lost_safe_cnt", {27'd0, safe_cnt}, 32'd1);
        chk("lost_win", {31'd0, win}, 32'd0);

        // Game 2: reveal every safe cell (with one duplicate) and win.
        do_start(bm);
        add_all_safe(bm, 1'b1);
        run_table();
        rev_valid = 1'b1;
        rev_idx   = 4'(first_cell(bm, 1'b1, 0));
        repeat (3) tick();
        rev_valid = 1'b0;
        chk("won_sticky", {31'd0, win}, 32'd1);
        chk("won_game_over", {31'd0, game_over}, 32'd0);
        chk("won_safe_cnt", {27'd0, safe_cnt}, 32'd12);
        chk("won_rev_ready", {31'd0, rev_ready}, 32'd0);

        // Game 3: start coincident with an accepted reveal discards the reveal.
        do_start(bm);
        s0 = first_cell(bm, 1'b0, 0);
        s1 = first_cell(bm, 1'b0, 1);
        add_vec(s0);
        run_table();
        rev_valid = 1'b1;
        rev_idx   = 4'(s1);
        do_start(bm);

        // Game 4: reset mid-PLACE, then the same offset must rebuild the first map.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check_reset_outputs("midplace");
        reset_seq(3);
        do_start(bm);
        m_bombs = bm_first;
        add_all_safe(bm_first, 1'b0);
        run_table();
        repeat (2) tick();
        chk("replay_win", {31'd0, win}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
